// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage. Owns the program counter and drives the
// instruction-memory request handshake. Writes the IF/ID pipeline register
// that the decode stage reads.
//
// When decode stalls, one fetched word can be parked in a 1-entry skid
// buffer. An execute-stage redirect flushes IF/ID and the buffer. If a fetch
// is still outstanding at that point, its response is awaited and then
// dropped.
//
// Optional feature (macro IF_STATIC_PRED_EN):
//   When defined, an accepted JAL word steers next_pc to pc + J-immediate,
//   and its IF/ID entry is tagged with IFID_pred = 1.
//   When undefined, next_pc is always pc + 4 and IFID_pred stays 0.
//
// Parameters:
//   RESET_PC  first PC fetched after reset release
//   NOP_INST  bubble encoding written into IF/ID when it holds no instruction
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   imem_req / imem_addr     fetch request; the address stays stable until ack
//   imem_ack / imem_rdata    response valid / instruction word
//   id_stall                 decode cannot accept; IF/ID holds
//   ex_redirect / ex_target  taken branch or mispredict, and its new PC
//   IFID_d_pc / IFID_d_inst  PC and instruction held in IF/ID
//   IFID_valid               IF/ID holds a real instruction
//   IFID_pred                entry was fetched under a taken prediction
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] IFID_d_pc,
  output logic [31:0] IFID_d_inst,
  output logic        IFID_valid,
  output logic        IFID_pred
);

  typedef enum logic [1:0] {FETCH, BUF, KILL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Low during the first cycle after reset release, which keeps imem_req low
  // until the first clock edge.
  logic        r_started;
  logic [31:0] r_pc;
  // Address of the request being killed; must stay on the bus until its ack.
  logic [31:0] r_kill_addr;

  logic        r_buf_valid;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic        r_buf_pred;

  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_inst;
  logic        r_ifid_pred;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_accept;
  logic        w_to_buf;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_pred;

  assign w_req    = r_started && (r_state != BUF);
  assign w_addr   = (r_state == KILL) ? r_kill_addr : r_pc;
  // A word is only consumed in FETCH; an ack that coincides with a redirect
  // is discarded.
  assign w_accept = (r_state == FETCH) && w_req && imem_ack && !ex_redirect;
  assign w_to_buf = w_accept && id_stall && r_ifid_valid;
  // Misaligned targets are silently aligned; no trap is raised here.
  assign w_target = ex_target & ~32'd3;

`ifdef IF_STATIC_PRED_EN
  logic        w_is_jal;
  logic [31:0] w_jimm;

  assign w_is_jal  = (imem_rdata[6:0] == 7'b1101111);
  assign w_jimm    = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign w_pred    = w_is_jal;
  assign w_next_pc = r_pc + (w_is_jal ? w_jimm : 32'd4);
`else
  assign w_pred    = 1'b0;
  assign w_next_pc = r_pc + 32'd4;
`endif

  assign imem_req    = w_req;
  assign imem_addr   = w_addr;
  assign IFID_d_pc   = r_ifid_pc;
  assign IFID_d_inst = r_ifid_inst;
  assign IFID_valid  = r_ifid_valid;
  assign IFID_pred   = r_ifid_pred;

  // State register and start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  // Next-state logic. A redirect wins over everything else. If a request is
  // still open it must be waited out in KILL.
  always_comb begin
    w_state_nxt = r_state;
    if (ex_redirect) begin
      w_state_nxt = (w_req && !imem_ack) ? KILL : FETCH;
    end else begin
      case (r_state)
        FETCH:   if (w_to_buf) w_state_nxt = BUF;
        BUF:     if (!id_stall) w_state_nxt = FETCH;
        KILL:    if (imem_ack) w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // PC and kill-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_kill_addr <= RESET_PC;
    end else if (ex_redirect) begin
      r_pc        <= w_target;
      r_kill_addr <= w_addr;
    end else if (w_accept) begin
      r_pc        <= w_next_pc;
    end
  end

  // Skid buffer: holds one word fetched while IF/ID is full and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= NOP_INST;
      r_buf_pred  <= 1'b0;
    end else if (ex_redirect) begin
      r_buf_valid <= 1'b0;
    end else if ((r_state == BUF) && !id_stall) begin
      r_buf_valid <= 1'b0;
    end else if (w_to_buf) begin
      r_buf_valid <= 1'b1;
      r_buf_pc    <= r_pc;
      r_buf_inst  <= imem_rdata;
      r_buf_pred  <= w_pred;
    end
  end

  // IF/ID register. Source priority is buffer, then fresh ack data, then a
  // bubble. A bubble leaves the PC field untouched.
  //
  // While stalled, IF/ID normally holds. If it only holds a bubble, though,
  // the accepted word is written straight in; otherwise that word would be
  // lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'd0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_pred  <= 1'b0;
    end else if (ex_redirect) begin
      r_ifid_valid <= 1'b0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_pred  <= 1'b0;
    end else if (!id_stall) begin
      if (r_buf_valid) begin
        r_ifid_valid <= 1'b1;
        r_ifid_pc    <= r_buf_pc;
        r_ifid_inst  <= r_buf_inst;
        r_ifid_pred  <= r_buf_pred;
      end else if (w_accept) begin
        r_ifid_valid <= 1'b1;
        r_ifid_pc    <= r_pc;
        r_ifid_inst  <= imem_rdata;
        r_ifid_pred  <= w_pred;
      end else begin
        r_ifid_valid <= 1'b0;
        r_ifid_inst  <= NOP_INST;
        r_ifid_pred  <= 1'b0;
      end
    end else if (w_accept && !r_ifid_valid) begin
      r_ifid_valid <= 1'b1;
      r_ifid_pc    <= r_pc;
      r_ifid_inst  <= imem_rdata;
      r_ifid_pred  <= w_pred;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Directed testbench for if_stage.
//
// Instance dut uses the default RESET_PC. Its instruction memory has a
// configurable latency.
//
// Instance dutWrap starts at 32'hFFFF_FFF8 with a 1-cycle memory, so the PC
// wrap can be observed.
//
// The memory returns a word derived from its address. Address 0x20 holds
// JAL x0,+16.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JAL_WORD = 32'h0100_006F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq, imemAck, idStall, exRedirect;
  logic [31:0] imemAddr, imemRdata, exTarget;
  logic [31:0] ifidPc, ifidInst;
  logic        ifidValid, ifidPred;

  logic        req2, ack2, valid2, pred2;
  logic [31:0] addr2, rdata2, pc2, inst2;

  int memLat = 1;
  int memCnt;
  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  // Word stored at each address of the model memory.
  function automatic logic [31:0] instFor(input logic [31:0] a);
    if (a == 32'h20) return JAL_WORD;
    return {a[26:2], 7'b0010011};
  endfunction

  // Memory model: acks once the request has been pending memLat-1 full cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) memCnt <= 0;
    else if (imemReq && !imemAck) memCnt <= memCnt + 1;
    else memCnt <= 0;
  end

  assign imemAck   = imemReq && (memCnt >= memLat - 1);
  assign imemRdata = instFor(imemAddr);
  assign ack2      = req2;
  assign rdata2    = instFor(addr2);

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ack(imemAck), .imem_rdata(imemRdata), .id_stall(idStall),
    .ex_redirect(exRedirect), .ex_target(exTarget), .IFID_d_pc(ifidPc),
    .IFID_d_inst(ifidInst), .IFID_valid(ifidValid), .IFID_pred(ifidPred)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .id_stall(1'b0),
    .ex_redirect(1'b0), .ex_target(32'd0), .IFID_d_pc(pc2),
    .IFID_d_inst(inst2), .IFID_valid(valid2), .IFID_pred(pred2)
  );

  // Protocol monitor: the address must not move while a request is unacked.
  initial begin
    logic        monPending;
    logic [31:0] monAddr;
    monPending = 1'b0;
    monAddr    = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        monPending = 1'b0;
      end else begin
        if (monPending) begin
          assertCount++;
          if (imemAddr !== monAddr) begin failCount++; $display("[TB] FAIL addr_stable: got %h expected %h", imemAddr, monAddr); end
        end
        monPending = imemReq && !imemAck;
        monAddr    = imemAddr;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic doReset(input int lat);
    memLat = lat; idStall = 1'b0; exRedirect = 1'b0; exTarget = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    memLat = 1; idStall = 1'b0; exRedirect = 1'b0; exTarget = 32'd0; rst_n = 1'b0;
    step(); step();
    assertCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL rst_req: got %h expected 0", imemReq); end
    assertCount++; if (ifidValid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_valid: got %h expected 0", ifidValid); end
    assertCount++; if (ifidInst !== NOP) begin failCount++; $display("[TB] FAIL rst_inst: got %h expected %h", ifidInst, NOP); end
    assertCount++; if (ifidPc !== 32'd0) begin failCount++; $display("[TB] FAIL rst_pc: got %h expected 0", ifidPc); end
    assertCount++; if (ifidPred !== 1'b0) begin failCount++; $display("[TB] FAIL rst_pred: got %h expected 0", ifidPred); end
    rst_n = 1'b1;
    #1;
    assertCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL rel_req_early: got %h expected 0", imemReq); end
    step();
    assertCount++; if (imemReq !== 1'b1) begin failCount++; $display("[TB] FAIL first_req: got %h expected 1", imemReq); end
    assertCount++; if (imemAddr !== 32'd0) begin failCount++; $display("[TB] FAIL first_addr: got %h expected 0", imemAddr); end
    assertCount++; if (addr2 !== 32'hFFFF_FFF8) begin failCount++; $display("[TB] FAIL first_addr_wrap: got %h expected fffffff8", addr2); end
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    assertCount++; if (ifidValid !== 1'b0) begin failCount++; $display("[TB] FAIL async_valid: got %h expected 0", ifidValid); end
    assertCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL async_req: got %h expected 0", imemReq); end
    assertCount++; if (ifidInst !== NOP) begin failCount++; $display("[TB] FAIL async_inst: got %h expected %h", ifidInst, NOP); end
  endtask

  task automatic test_sequential();
    doReset(1);
    step();
    assertCount++; if (imemAddr !== 32'd0) begin failCount++; $display("[TB] FAIL seq_addr0: got %h expected 0", imemAddr); end
    assertCount++; if (ifidValid !== 1'b0) begin failCount++; $display("[TB] FAIL seq_valid0: got %h expected 0", ifidValid); end
    for (int i = 1; i <= 4; i++) begin
      logic [31:0] expAddr, expPc;
      expAddr = 32'(4 * i);
      expPc   = 32'(4 * (i - 1));
      step();
      assertCount++; if (imemAddr !== expAddr) begin failCount++; $display("[TB] FAIL seq_addr: got %h expected %h", imemAddr, expAddr); end
      assertCount++; if (ifidPc !== expPc) begin failCount++; $display("[TB] FAIL seq_pc: got %h expected %h", ifidPc, expPc); end
      assertCount++; if (ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL seq_valid: got %h expected 1", ifidValid); end
      assertCount++; if (ifidInst !== instFor(expPc)) begin failCount++; $display("[TB] FAIL seq_inst: got %h expected %h", ifidInst, instFor(expPc)); end
    end
  endtask

  task automatic waitPc8();
    for (int k = 0; k < 20; k++) begin
      if (ifidValid === 1'b1 && ifidPc === 32'd8) break;
      step();
    end
    assertCount++; if (!(ifidValid === 1'b1 && ifidPc === 32'd8)) begin failCount++; $display("[TB] FAIL wait_pc8: got %h expected 00000008", ifidPc); end
  endtask

  task automatic test_stall();
    doReset(1);
    waitPc8();
    idStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      assertCount++; if (ifidPc !== 32'd8) begin failCount++; $display("[TB] FAIL stall_pc: got %h expected 8", ifidPc); end
      assertCount++; if (ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL stall_valid: got %h expected 1", ifidValid); end
      assertCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL stall_req: got %h expected 0", imemReq); end
    end
    idStall = 1'b0;
    step();
    assertCount++; if (ifidPc !== 32'd12) begin failCount++; $display("[TB] FAIL unstall_pc: got %h expected c", ifidPc); end
    assertCount++; if (ifidInst !== instFor(32'd12)) begin failCount++; $display("[TB] FAIL unstall_inst: got %h expected %h", ifidInst, instFor(32'd12)); end
    assertCount++; if (imemAddr !== 32'd16) begin failCount++; $display("[TB] FAIL unstall_addr: got %h expected 10", imemAddr); end
    step();
    assertCount++; if (ifidPc !== 32'd16) begin failCount++; $display("[TB] FAIL unstall_pc2: got %h expected 10", ifidPc); end
    assertCount++; if (ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL unstall_valid2: got %h expected 1", ifidValid); end
  endtask

  // Three-cycle memory; redirect to 0x100 while the fetch of 4 is pending.
  // The optional second redirect is issued while already in KILL.
  task automatic test_redirect(input logic second, input logic [31:0] tgt2, input logic [31:0] expPc);
    doReset(3);
    step(); step(); step(); step();
    assertCount++; if (ifidPc !== 32'd0 || ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL rd_first: got %h expected 0", ifidPc); end
    exRedirect = 1'b1; exTarget = 32'h100;
    step();
    exRedirect = second; exTarget = tgt2;
    assertCount++; if (ifidValid !== 1'b0) begin failCount++; $display("[TB] FAIL rd_flush: got %h expected 0", ifidValid); end
    assertCount++; if (ifidInst !== NOP) begin failCount++; $display("[TB] FAIL rd_nop: got %h expected %h", ifidInst, NOP); end
    assertCount++; if (imemAddr !== 32'd4 || imemReq !== 1'b1) begin failCount++; $display("[TB] FAIL rd_kill_addr: got %h expected 4", imemAddr); end
    step();
    exRedirect = 1'b0;
    assertCount++; if (imemAddr !== 32'd4) begin failCount++; $display("[TB] FAIL rd_kill_addr2: got %h expected 4", imemAddr); end
    assertCount++; if (imemAck !== 1'b1) begin failCount++; $display("[TB] FAIL rd_old_ack: got %h expected 1", imemAck); end
    step();
    assertCount++; if (imemAddr !== expPc) begin failCount++; $display("[TB] FAIL rd_new_addr: got %h expected %h", imemAddr, expPc); end
    for (int i = 0; i < 3; i++) begin
      assertCount++; if (ifidValid !== 1'b0) begin failCount++; $display("[TB] FAIL rd_bubble: got %h expected 0", ifidValid); end
      step();
    end
    assertCount++; if (ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL rd_valid: got %h expected 1", ifidValid); end
    assertCount++; if (ifidPc !== expPc) begin failCount++; $display("[TB] FAIL rd_pc: got %h expected %h", ifidPc, expPc); end
    assertCount++; if (ifidInst !== instFor(expPc)) begin failCount++; $display("[TB] FAIL rd_inst: got %h expected %h", ifidInst, instFor(expPc)); end
  endtask

  task automatic test_redirect_stall();
    doReset(1);
    waitPc8();
    idStall = 1'b1;
    step();
    assertCount++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL rs_buf_req: got %h expected 0", imemReq); end
    exRedirect = 1'b1; exTarget = 32'h40;
    step();
    exRedirect = 1'b0; idStall = 1'b0;
    assertCount++; if (ifidValid !== 1'b0) begin failCount++; $display("[TB] FAIL rs_valid: got %h expected 0", ifidValid); end
    assertCount++; if (ifidInst !== NOP) begin failCount++; $display("[TB] FAIL rs_inst: got %h expected %h", ifidInst, NOP); end
    assertCount++; if (ifidPc !== 32'd8) begin failCount++; $display("[TB] FAIL rs_pc_hold: got %h expected 8", ifidPc); end
    assertCount++; if (imemAddr !== 32'h40 || imemReq !== 1'b1) begin failCount++; $display("[TB] FAIL rs_addr: got %h expected 40", imemAddr); end
    step();
    assertCount++; if (ifidPc !== 32'h40 || ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL rs_next_pc: got %h expected 40", ifidPc); end
    step();
    assertCount++; if (ifidPc !== 32'h44) begin failCount++; $display("[TB] FAIL rs_next_pc2: got %h expected 44", ifidPc); end
  endtask

  task automatic test_wrap();
    doReset(1);
    step();
    assertCount++; if (addr2 !== 32'hFFFF_FFF8) begin failCount++; $display("[TB] FAIL wrap_a0: got %h expected fffffff8", addr2); end
    step();
    assertCount++; if (addr2 !== 32'hFFFF_FFFC) begin failCount++; $display("[TB] FAIL wrap_a1: got %h expected fffffffc", addr2); end
    assertCount++; if (pc2 !== 32'hFFFF_FFF8 || valid2 !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_p0: got %h expected fffffff8", pc2); end
    step();
    assertCount++; if (addr2 !== 32'd0) begin failCount++; $display("[TB] FAIL wrap_a2: got %h expected 0", addr2); end
    assertCount++; if (pc2 !== 32'hFFFF_FFFC) begin failCount++; $display("[TB] FAIL wrap_p1: got %h expected fffffffc", pc2); end
    step();
    assertCount++; if (pc2 !== 32'd0 || valid2 !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_p2: got %h expected 0", pc2); end
  endtask

  task automatic test_static_pred();
    logic [31:0] expNext;
    logic        expPred;
`ifdef IF_STATIC_PRED_EN
    expNext = 32'h30; expPred = 1'b1;
`else
    expNext = 32'h24; expPred = 1'b0;
`endif
    doReset(1);
    for (int k = 0; k < 20; k++) begin
      if (imemAddr === 32'h20 && imemReq === 1'b1) break;
      step();
    end
    assertCount++; if (imemAddr !== 32'h20) begin failCount++; $display("[TB] FAIL pred_reach: got %h expected 20", imemAddr); end
    step();
    assertCount++; if (ifidPc !== 32'h20) begin failCount++; $display("[TB] FAIL pred_pc: got %h expected 20", ifidPc); end
    assertCount++; if (ifidInst !== JAL_WORD) begin failCount++; $display("[TB] FAIL pred_inst: got %h expected %h", ifidInst, JAL_WORD); end
    assertCount++; if (ifidPred !== expPred) begin failCount++; $display("[TB] FAIL pred_flag: got %h expected %h", ifidPred, expPred); end
    assertCount++; if (imemAddr !== expNext) begin failCount++; $display("[TB] FAIL pred_next_addr: got %h expected %h", imemAddr, expNext); end
    step();
    assertCount++; if (ifidPc !== expNext || ifidValid !== 1'b1) begin failCount++; $display("[TB] FAIL pred_next_pc: got %h expected %h", ifidPc, expNext); end
  endtask

  initial begin
    idStall = 1'b0; exRedirect = 1'b0; exTarget = 32'd0;
    $display("[TB] starting if_stage tests");
    test_reset();
    test_sequential();
    test_stall();
    test_redirect(1'b0, 32'd0, 32'h100);
    test_redirect(1'b1, 32'h203, 32'h200);
    test_redirect_stall();
    test_wrap();
    test_static_pred();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
